// File: rtl/auth_pkg.sv
// Shared constants for the multi-user authentication path: ROM geometry,
// arbiter state encodings and the CheckID user-slot map.
package auth_pkg;

  localparam int ADDR_W_DEF  = 5;
  localparam int DATA_W_DEF  = 16;
  localparam int NUM_ENTRIES = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } arb_state_t;

  // CheckID user slots: ROM address of each user's credential word
  localparam logic [4:0] SLOT_MEMBER0 = 5'd0;
  localparam logic [4:0] SLOT_MEMBER1 = 5'd1;
  localparam logic [4:0] SLOT_MEMBER2 = 5'd2;
  localparam logic [4:0] SLOT_MEMBER3 = 5'd3;
  localparam logic [4:0] SLOT_GUEST   = 5'd4;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin chooser; on a tie the requester that was
// not granted last time wins.
module rr_pick2 (
  input  logic Req0,
  input  logic Req1,
  input  logic LastGrant,
  output logic GrantValid,
  output logic GrantIdx
);

  assign GrantValid = Req0 | Req1;
  assign GrantIdx   = (Req0 & Req1) ? ~LastGrant : Req1;

endmodule

// File: rtl/auth_rom_arbiter.sv
// Time-shares one single-port synchronous credential ROM between the ID
// checker (port 0) and the password checker (port 1).
//
// state   | meaning
// IDLE    | waiting for a request; arbitrate and latch the address
// WAIT    | counting down the ROM read latency
// CAPTURE | register RomQ and pulse the granted Valid
// DONE    | Valid visible; release the grant
module auth_rom_arbiter
  import auth_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int ROM_LATENCY = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Req0,
  input  logic [ADDR_W-1:0] Addr0,
  input  logic              Req1,
  input  logic [ADDR_W-1:0] Addr1,
  output logic              Grant0,
  output logic              Grant1,
  output logic              Valid0,
  output logic              Valid1,
  output logic [DATA_W-1:0] RdData,
  output logic              RangeErr,
  output logic              Busy,
  output logic [ADDR_W-1:0] RomAddr,
  input  logic [DATA_W-1:0] RomQ
);

  localparam logic [1:0]      WAIT_INIT = 2'(ROM_LATENCY - 1);
  localparam logic [ADDR_W:0] ADDR_LIM  = (ADDR_W + 1)'(NUM_ENTRIES);

  arb_state_t        state, state_nx;
  logic [1:0]        wait_cnt, wait_nx;
  logic              last_grant, last_nx;
  logic [ADDR_W-1:0] addr_nx;
  logic [DATA_W-1:0] data_nx;
  logic              err_nx, g0_nx, g1_nx, v0_nx, v1_nx;

  logic              pick_valid, pick_idx;
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_oor;

  rr_pick2 u_pick (
    .Req0       (Req0),
    .Req1       (Req1),
    .LastGrant  (last_grant),
    .GrantValid (pick_valid),
    .GrantIdx   (pick_idx)
  );

  assign sel_addr = pick_idx ? Addr1 : Addr0;
  assign sel_oor  = ({1'b0, sel_addr} >= ADDR_LIM);
  assign Busy     = (state != IDLE);

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state      <= IDLE;
      wait_cnt   <= 2'd0;
      last_grant <= 1'b1;
      RomAddr    <= '0;
      RdData     <= '0;
      RangeErr   <= 1'b0;
      Grant0     <= 1'b0;
      Grant1     <= 1'b0;
      Valid0     <= 1'b0;
      Valid1     <= 1'b0;
    end else begin
      state      <= state_nx;
      wait_cnt   <= wait_nx;
      last_grant <= last_nx;
      RomAddr    <= addr_nx;
      RdData     <= data_nx;
      RangeErr   <= err_nx;
      Grant0     <= g0_nx;
      Grant1     <= g1_nx;
      Valid0     <= v0_nx;
      Valid1     <= v1_nx;
    end
  end

  always_comb begin
    state_nx = state;
    wait_nx  = wait_cnt;
    last_nx  = last_grant;
    addr_nx  = RomAddr;
    data_nx  = RdData;
    err_nx   = RangeErr;
    g0_nx    = Grant0;
    g1_nx    = Grant1;
    v0_nx    = 1'b0;
    v1_nx    = 1'b0;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          g0_nx   = ~pick_idx;
          g1_nx   = pick_idx;
          last_nx = pick_idx;
          addr_nx = sel_addr;
          // out-of-range addresses answer immediately without touching the ROM
          if (sel_oor) begin
            err_nx   = 1'b1;
            data_nx  = '0;
            v0_nx    = ~pick_idx;
            v1_nx    = pick_idx;
            state_nx = DONE;
          end else begin
            wait_nx  = WAIT_INIT;
            state_nx = WAIT;
          end
        end
      end
      WAIT: begin
        if (wait_cnt == 2'd0) state_nx = CAPTURE;
        else                  wait_nx  = wait_cnt - 2'd1;
      end
      CAPTURE: begin
        data_nx  = RomQ;
        err_nx   = 1'b0;
        v0_nx    = Grant0;
        v1_nx    = Grant1;
        state_nx = DONE;
      end
      DONE: begin
        g0_nx    = 1'b0;
        g1_nx    = 1'b0;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule
